// File: rtl/usfft_seq_ctrl_if.sv
// Host/config and uSFFT-core handshake bundle for the uSFFT run sequencer.
// The sequencer connects through the slave modport; the host side uses master.
interface usfft_seq_ctrl_if #(
  parameter int BITWIDTH = 8
);
  logic                iCfgValid;
  logic                oCfgReady;
  logic [BITWIDTH-1:0] iCfgReal;
  logic [BITWIDTH-1:0] iCfgImg;
  logic                iStart;
  logic                iAbort;
  logic [BITWIDTH-1:0] oWReal;
  logic [BITWIDTH-1:0] oWImg;
  logic                oLoadW;
  logic                oClr;
  logic                oSrcEn;
  logic [BITWIDTH-1:0] oCnt;
  logic                oBusy;
  logic                oDone;

  modport master (
    output iCfgValid, iCfgReal, iCfgImg, iStart, iAbort,
    input  oCfgReady, oWReal, oWImg, oLoadW, oClr, oSrcEn, oCnt, oBusy, oDone
  );

  modport slave (
    input  iCfgValid, iCfgReal, iCfgImg, iStart, iAbort,
    output oCfgReady, oWReal, oWImg, oLoadW, oClr, oSrcEn, oCnt, oBusy, oDone
  );
endinterface

// File: rtl/usfft_seq_ctrl.sv
// Run sequencer for the 4-point uSFFT core: loadW, clear, then one 2^BITWIDTH-cycle source frame.
// Start-to-done latency 3+2^BITWIDTH cycles; config is backpressured (oCfgReady=0) only in LOAD.
module usfft_seq_ctrl #(
  parameter int BITWIDTH = 8
) (
  input  logic            iClk,
  input  logic            iRst,
  usfft_seq_ctrl_if.slave bus
);

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_LOAD = 3'd1;
  localparam logic [2:0] ST_CLR  = 3'd2;
  localparam logic [2:0] ST_RUN  = 3'd3;
  localparam logic [2:0] ST_DONE = 3'd4;

  localparam logic [BITWIDTH-1:0] CNT_LAST = '1;
  localparam logic [BITWIDTH-1:0] CNT_ONE  = {{(BITWIDTH-1){1'b0}}, 1'b1};

  logic [2:0]          state;
  logic [BITWIDTH-1:0] cnt;
  logic [BITWIDTH-1:0] w_real;
  logic [BITWIDTH-1:0] w_img;
  logic                cfg_ready;
  logic                cfg_fire;

  // The core samples the weights during LOAD, so the shadow must hold still then.
  assign cfg_ready = (state != ST_LOAD);
  assign cfg_fire  = bus.iCfgValid && cfg_ready;

  always_ff @(posedge iClk) begin
    if (iRst) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      w_real <= '0;
      w_img  <= '0;
    end else begin
      if (cfg_fire) begin
        w_real <= bus.iCfgReal;
        w_img  <= bus.iCfgImg;
      end
      case (state)
        ST_IDLE: begin
          if (bus.iStart) state <= ST_LOAD;
        end
        ST_LOAD: begin
          state <= bus.iAbort ? ST_IDLE : ST_CLR;
        end
        ST_CLR: begin
          cnt   <= '0;
          state <= bus.iAbort ? ST_IDLE : ST_RUN;
        end
        ST_RUN: begin
          // Abort beats the terminal count, and the wrap leaves cnt at 0 for the next frame.
          if (bus.iAbort) begin
            state <= ST_IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CNT_ONE;
            if (cnt == CNT_LAST) state <= ST_DONE;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  assign bus.oCfgReady = cfg_ready;
  assign bus.oWReal    = w_real;
  assign bus.oWImg     = w_img;
  assign bus.oLoadW    = (state == ST_LOAD);
  assign bus.oClr      = (state == ST_CLR);
  assign bus.oSrcEn    = (state == ST_RUN);
  assign bus.oCnt      = cnt;
  assign bus.oBusy     = (state != ST_IDLE);
  assign bus.oDone     = (state == ST_DONE);

endmodule

// File: tb/tb_usfft_seq_ctrl.sv
// Bench for usfft_seq_ctrl: frame-position reference model checked every cycle plus directed literal checks.
module tb_usfft_seq_ctrl;
  localparam int BW = 8;
  localparam int N  = 1 << BW;

  logic clk = 1'b0;
  logic rst = 1'b1;

  usfft_seq_ctrl_if #(.BITWIDTH(BW)) bus();

  usfft_seq_ctrl #(.BITWIDTH(BW)) dut (
    .iClk(clk),
    .iRst(rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int vectors    = 0;
  int miscompares = 0;

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: m_pos is the cycle index within a frame (0 = idle, 1 = load ... 3+N = done).
  int              m_pos = 0;
  logic [BW-1:0]   m_wr  = '0;
  logic [BW-1:0]   m_wi  = '0;
  bit              chk_en = 1'b0;

  always @(posedge clk) begin
    int            np;
    logic [BW-1:0] nr, ni;
    np = m_pos; nr = m_wr; ni = m_wi;
    if (rst) begin
      np = 0; nr = '0; ni = '0;
    end else begin
      if (bus.iCfgValid && m_pos != 1) begin
        nr = bus.iCfgReal;
        ni = bus.iCfgImg;
      end
      if (m_pos == 0)                         np = bus.iStart ? 1 : 0;
      else if (bus.iAbort && m_pos <= 2 + N)  np = 0;
      else if (m_pos == 3 + N)                np = 0;
      else                                    np = m_pos + 1;
    end
    m_pos  <= np;
    m_wr   <= nr;
    m_wi   <= ni;
    chk_en <= 1'b1;
  end

  always @(negedge clk) begin
    if (chk_en) begin
      bit src;
      src = (m_pos >= 3) && (m_pos <= 2 + N);
      chk("cfg_ready", int'(bus.oCfgReady), int'(m_pos != 1));
      chk("w_real",    int'(bus.oWReal),    int'(m_wr));
      chk("w_img",     int'(bus.oWImg),     int'(m_wi));
      chk("load_w",    int'(bus.oLoadW),    int'(m_pos == 1));
      chk("clr",       int'(bus.oClr),      int'(m_pos == 2));
      chk("src_en",    int'(bus.oSrcEn),    int'(src));
      chk("cnt",       int'(bus.oCnt),      src ? m_pos - 3 : 0);
      chk("busy",      int'(bus.oBusy),     int'(m_pos != 0));
      chk("done",      int'(bus.oDone),     int'(m_pos == 3 + N));
    end
  end

  // Observations of one frame, relative to the edge that sampled iStart.
  int            t_load, t_clr, t_src0, n_src, t_done, n_done, t_abort;
  int            cnt0, last_cnt, w_at3;
  logic [BW-1:0] ld_real, ld_img;
  bit            ready_at_load, busy_after, src_after;

  task automatic observe(input int abort_at, input bit cfg_in_load,
                         input logic [BW-1:0] lr, input logic [BW-1:0] li);
    t_load = -1; t_clr = -1; t_src0 = -1; n_src = 0; t_done = -1; n_done = 0; t_abort = -1;
    cnt0 = -1; last_cnt = -1; w_at3 = -1; ld_real = '0; ld_img = '0;
    ready_at_load = 1'b1; busy_after = 1'b1; src_after = 1'b1;
    for (int k = 1; k <= 300; k++) begin
      @(negedge clk);
      if (bus.oLoadW) begin
        if (t_load < 0) t_load = k;
        ld_real = bus.oWReal; ld_img = bus.oWImg; ready_at_load = bus.oCfgReady;
      end
      if (bus.oClr && t_clr < 0) t_clr = k;
      if (bus.oSrcEn) begin
        if (t_src0 < 0) begin t_src0 = k; cnt0 = int'(bus.oCnt); end
        n_src++;
        last_cnt = int'(bus.oCnt);
      end
      if (bus.oDone) begin n_done++; t_done = k; end
      if (k == 3) w_at3 = int'(bus.oWReal);
      if (t_abort >= 0 && k == t_abort + 1) begin
        busy_after = bus.oBusy; src_after = bus.oSrcEn; bus.iAbort = 1'b0;
      end
      if (cfg_in_load && k == 1) begin
        bus.iCfgValid = 1'b1; bus.iCfgReal = lr; bus.iCfgImg = li;
      end
      if (cfg_in_load && k == 3) bus.iCfgValid = 1'b0;
      if (abort_at >= 0 && t_abort < 0 && bus.oSrcEn && int'(bus.oCnt) == abort_at) begin
        bus.iAbort = 1'b1; t_abort = k;
      end
    end
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 bus.iStart = 1'b1;
    @(posedge clk); #1 bus.iStart = 1'b0;
  endtask

  initial begin
    int d1, d2, d3, nd, dn_after;
    bus.iCfgValid = 1'b0; bus.iCfgReal = '0; bus.iCfgImg = '0;
    bus.iStart = 1'b0; bus.iAbort = 1'b0;

    // Reset and idle
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_cfg_ready", int'(bus.oCfgReady), 1);
    chk("rst_w_real", int'(bus.oWReal), 0);
    chk("rst_busy", int'(bus.oBusy), 0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("idle_src_en", int'(bus.oSrcEn), 0);
    end

    // Nominal frame
    @(posedge clk); #1 bus.iCfgValid = 1'b1; bus.iCfgReal = 8'hB5; bus.iCfgImg = 8'h4A;
    @(posedge clk); #1 bus.iCfgValid = 1'b0; bus.iStart = 1'b1;
    @(posedge clk); #1 bus.iStart = 1'b0;
    observe(-1, 1'b0, '0, '0);
    chk("nom_t_load", t_load, 1);
    chk("nom_ld_real", int'(ld_real), 8'hB5);
    chk("nom_ld_img", int'(ld_img), 8'h4A);
    chk("nom_t_clr", t_clr, 2);
    chk("nom_t_src0", t_src0, 3);
    chk("nom_cnt0", cnt0, 0);
    chk("nom_n_src", n_src, 256);
    chk("nom_last_cnt", last_cnt, 255);
    chk("nom_t_done", t_done, 259);
    chk("nom_n_done", n_done, 1);

    // Same-cycle config+start, config held during LOAD, abort at count 100
    @(posedge clk); #1 bus.iCfgValid = 1'b1; bus.iCfgReal = 8'h10; bus.iCfgImg = 8'h20; bus.iStart = 1'b1;
    @(posedge clk); #1 bus.iCfgValid = 1'b0; bus.iStart = 1'b0;
    observe(100, 1'b1, 8'h77, 8'h88);
    chk("sc_ld_real", int'(ld_real), 8'h10);
    chk("sc_ld_img", int'(ld_img), 8'h20);
    chk("load_cfg_ready", int'(ready_at_load), 0);
    chk("clr_cfg_taken", w_at3, 8'h77);
    chk("abort_last_cnt", last_cnt, 100);
    chk("abort_busy_after", int'(busy_after), 0);
    chk("abort_src_after", int'(src_after), 0);
    chk("abort_n_done", n_done, 0);

    // Full frame after abort
    pulse_start();
    observe(-1, 1'b0, '0, '0);
    chk("post_abort_ld_real", int'(ld_real), 8'h77);
    chk("post_abort_cnt0", cnt0, 0);
    chk("post_abort_n_src", n_src, 256);
    chk("post_abort_t_done", t_done, 259);

    // Abort coinciding with the terminal count
    pulse_start();
    observe(255, 1'b0, '0, '0);
    chk("term_abort_n_done", n_done, 0);
    chk("term_abort_busy_after", int'(busy_after), 0);

    // Back-to-back frames with iStart held
    @(posedge clk); #1 bus.iStart = 1'b1;
    d1 = -1; d2 = -1; d3 = -1; nd = 0;
    for (int k = 1; k <= 1000 && nd < 3; k++) begin
      @(negedge clk);
      if (bus.oDone) begin
        nd++;
        if (nd == 1) d1 = k; else if (nd == 2) d2 = k; else d3 = k;
      end
    end
    chk("b2b_n_done", nd, 3);
    chk("b2b_period1", d2 - d1, 260);
    chk("b2b_period2", d3 - d2, 260);

    // Mid-run reset
    repeat (50) @(negedge clk);
    chk("midrun_busy", int'(bus.oBusy), 1);
    rst = 1'b1; bus.iStart = 1'b0;
    @(negedge clk);
    chk("mr_cfg_ready", int'(bus.oCfgReady), 1);
    chk("mr_busy", int'(bus.oBusy), 0);
    chk("mr_src_en", int'(bus.oSrcEn), 0);
    chk("mr_cnt", int'(bus.oCnt), 0);
    chk("mr_w_real", int'(bus.oWReal), 0);
    rst = 1'b0;
    dn_after = 0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (bus.oDone) dn_after++;
    end
    chk("mr_no_done", dn_after, 0);

    // Randomized traffic
    for (int i = 0; i < 4000; i++) begin
      @(posedge clk); #1;
      bus.iCfgValid = ($urandom_range(0, 99) < 25);
      bus.iCfgReal  = BW'($urandom);
      bus.iCfgImg   = BW'($urandom);
      bus.iStart    = ($urandom_range(0, 99) < 3);
      bus.iAbort    = ($urandom_range(0, 999) < 8);
      rst           = ($urandom_range(0, 999) < 1);
    end
    @(posedge clk); #1;
    bus.iCfgValid = 1'b0; bus.iStart = 1'b0; bus.iAbort = 1'b0; rst = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
